// File: rtl/rob_completion_buffer.sv
// Reorder buffer behind the multiplier M5 writeback: grants rob_ids at issue, absorbs
// out-of-order completions and retires entries to register-file commit in allocation order.
module rob_completion_buffer #(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WIDTH = 3,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [WORD_SIZE-1:0]       alloc_pc,
  input  logic [REG_ADDR_W-1:0]      alloc_rd,
  input  logic [INSTR_TYPE_SZ-1:0]   alloc_instr_type,
  output logic                       alloc_ready,
  output logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,
  input  logic                       wb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  input  logic [WORD_SIZE-1:0]       wb_result,
  output logic                       commit_valid,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
  output logic [REG_ADDR_W-1:0]      commit_rd,
  output logic [WORD_SIZE-1:0]       commit_result,
  output logic [WORD_SIZE-1:0]       commit_pc,
  output logic [INSTR_TYPE_SZ-1:0]   commit_instr_type,
  output logic                       empty
);

  localparam int DEPTH = 1 << ROB_ENTRY_WIDTH;
  localparam logic [ROB_ENTRY_WIDTH:0] FULL_CNT = (ROB_ENTRY_WIDTH+1)'(DEPTH);
  localparam logic [ROB_ENTRY_WIDTH-1:0] ID_ONE = ROB_ENTRY_WIDTH'(1);

  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [DEPTH-1:0]           done_q, done_d;
  logic [ROB_ENTRY_WIDTH-1:0] head_q, head_d;
  logic [ROB_ENTRY_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_ENTRY_WIDTH:0]   count_q, count_d;

  logic [WORD_SIZE-1:0]     pc_q     [DEPTH];
  logic [REG_ADDR_W-1:0]    rd_q     [DEPTH];
  logic [INSTR_TYPE_SZ-1:0] type_q   [DEPTH];
  logic [WORD_SIZE-1:0]     result_q [DEPTH];

  logic                       commit_valid_q;
  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id_q;
  logic [REG_ADDR_W-1:0]      commit_rd_q;
  logic [WORD_SIZE-1:0]       commit_result_q;
  logic [WORD_SIZE-1:0]       commit_pc_q;
  logic [INSTR_TYPE_SZ-1:0]   commit_instr_type_q;

  logic alloc_fire, wb_fire, retire;

  // Full is judged on registered count only; a same-edge retire does not free a slot.
  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign wb_fire     = wb_valid && busy_q[wb_rob_id];
  assign retire      = busy_q[head_q] && done_q[head_q];

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wb_fire) begin
      done_d[wb_rob_id] = 1'b1;
    end
    // Retire after completion so a repeated completion to the head cannot resurrect it.
    if (retire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + ID_ONE;
    end
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + ID_ONE;
    end
    unique case ({alloc_fire, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage is not reset; busy/done alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]   <= alloc_pc;
      rd_q[tail_q]   <= alloc_rd;
      type_q[tail_q] <= alloc_instr_type;
    end
    if (wb_fire) begin
      result_q[wb_rob_id] <= wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid_q      <= 1'b0;
      commit_rob_id_q     <= '0;
      commit_rd_q         <= '0;
      commit_result_q     <= '0;
      commit_pc_q         <= '0;
      commit_instr_type_q <= '0;
    end else begin
      commit_valid_q <= retire;
      if (retire) begin
        commit_rob_id_q     <= head_q;
        commit_rd_q         <= rd_q[head_q];
        commit_result_q     <= result_q[head_q];
        commit_pc_q         <= pc_q[head_q];
        commit_instr_type_q <= type_q[head_q];
      end
    end
  end

  assign alloc_rob_id      = tail_q;
  assign empty             = (count_q == '0);
  assign commit_valid      = commit_valid_q;
  assign commit_rob_id     = commit_rob_id_q;
  assign commit_rd         = commit_rd_q;
  assign commit_result     = commit_result_q;
  assign commit_pc         = commit_pc_q;
  assign commit_instr_type = commit_instr_type_q;

endmodule

// File: tb/tb_rob_completion_buffer.sv
// Directed bench for rob_completion_buffer: in-order, out-of-order, full/wrap,
// stale completion, alloc/completion collision and mid-flight reset.
module tb_rob_completion_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_rd;
  logic [1:0]  alloc_instr_type;
  logic        alloc_ready;
  logic [2:0]  alloc_rob_id;
  logic        wb_valid;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_result;
  logic        commit_valid;
  logic [2:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_result;
  logic [31:0] commit_pc;
  logic [1:0]  commit_instr_type;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  rob_completion_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_valid       (alloc_valid),
    .alloc_pc          (alloc_pc),
    .alloc_rd          (alloc_rd),
    .alloc_instr_type  (alloc_instr_type),
    .alloc_ready       (alloc_ready),
    .alloc_rob_id      (alloc_rob_id),
    .wb_valid          (wb_valid),
    .wb_rob_id         (wb_rob_id),
    .wb_result         (wb_result),
    .commit_valid      (commit_valid),
    .commit_rob_id     (commit_rob_id),
    .commit_rd         (commit_rd),
    .commit_result     (commit_result),
    .commit_pc         (commit_pc),
    .commit_instr_type (commit_instr_type),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [1:0] typ, input logic [2:0] exp_id);
    alloc_valid      = 1'b1;
    alloc_pc         = pc;
    alloc_rd         = rd;
    alloc_instr_type = typ;
    check("alloc_id", alloc_rob_id, exp_id);
    check("alloc_ready", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [2:0] id, input logic [31:0] res);
    wb_valid  = 1'b1;
    wb_rob_id = id;
    wb_result = res;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic expect_commit(input string tag, input logic [2:0] id, input logic [31:0] res,
                               input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] typ);
    check({tag, "_valid"}, commit_valid, 1);
    check({tag, "_id"}, commit_rob_id, id);
    check({tag, "_result"}, commit_result, res);
    check({tag, "_pc"}, commit_pc, pc);
    check({tag, "_rd"}, commit_rd, rd);
    check({tag, "_type"}, commit_instr_type, typ);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [2:0] last_id;
    reset = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; alloc_rd = '0; alloc_instr_type = '0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_result = '0;

    // Reset held for two cycles.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_alloc_id", alloc_rob_id, 0);

    // In-order completion.
    do_alloc(32'h100, 5'd5, 2'd1, 3'd0);
    do_alloc(32'h104, 5'd6, 2'd2, 3'd1);
    do_alloc(32'h108, 5'd7, 2'd3, 3'd2);
    check("ino_not_empty", empty, 0);
    do_wb(3'd0, 32'hA);
    check("ino_no_commit_yet", commit_valid, 0);
    do_wb(3'd1, 32'hB);
    expect_commit("ino0", 3'd0, 32'hA, 32'h100, 5'd5, 2'd1);
    do_wb(3'd2, 32'hC);
    expect_commit("ino1", 3'd1, 32'hB, 32'h104, 5'd6, 2'd2);
    tick();
    expect_commit("ino2", 3'd2, 32'hC, 32'h108, 5'd7, 2'd3);
    tick();
    check("ino_idle", commit_valid, 0);
    check("ino_empty", empty, 1);

    // Out-of-order completion: nothing retires until the oldest is done.
    reset_dut();
    do_alloc(32'h400, 5'd1, 2'd0, 3'd0);
    do_alloc(32'h404, 5'd2, 2'd1, 3'd1);
    do_alloc(32'h408, 5'd3, 2'd2, 3'd2);
    do_wb(3'd2, 32'h22);
    check("ooo_wait_a", commit_valid, 0);
    do_wb(3'd1, 32'h11);
    check("ooo_wait_b", commit_valid, 0);
    do_wb(3'd0, 32'h00);
    check("ooo_wait_c", commit_valid, 0);
    tick();
    expect_commit("ooo0", 3'd0, 32'h00, 32'h400, 5'd1, 2'd0);
    tick();
    expect_commit("ooo1", 3'd1, 32'h11, 32'h404, 5'd2, 2'd1);
    tick();
    expect_commit("ooo2", 3'd2, 32'h22, 32'h408, 5'd3, 2'd2);
    tick();
    check("ooo_idle", commit_valid, 0);
    check("ooo_empty", empty, 1);

    // Fill to full, ignored 9th alloc, wrap of tail to id 0.
    reset_dut();
    for (int i = 0; i < 8; i++)
      do_alloc(32'h200 + 32'(4 * i), 5'(i), 2'(i), 3'(i));
    check("full_ready", alloc_ready, 0);
    check("full_not_empty", empty, 0);
    alloc_valid = 1'b1; alloc_pc = 32'hDEAD; alloc_rd = 5'd31; alloc_instr_type = 2'd3;
    tick();
    alloc_valid = 1'b0;
    check("full_ignored_ready", alloc_ready, 0);
    check("full_tail_wrapped", alloc_rob_id, 0);
    do_wb(3'd0, 32'h55);
    check("full_still_full", alloc_ready, 0);
    tick();
    expect_commit("wrap0", 3'd0, 32'h55, 32'h200, 5'd0, 2'd0);
    check("wrap_ready", alloc_ready, 1);
    do_alloc(32'h900, 5'd9, 2'd0, 3'd0);
    check("refull_ready", alloc_ready, 0);
    // Drain ids 1..7 then 0; the first retire coincides with a blocked alloc.
    for (int k = 0; k < 8; k++) begin
      int id;
      id = (k + 1) % 8;
      do_wb(3'(id), 32'h1000 + 32'(id));
      if (k == 0) begin
        alloc_valid = 1'b1; alloc_pc = 32'hBAD; alloc_rd = 5'd30; alloc_instr_type = 2'd1;
      end
      tick();
      alloc_valid = 1'b0;
      if (id == 0)
        expect_commit("drain", 3'd0, 32'h1000, 32'h900, 5'd9, 2'd0);
      else
        expect_commit("drain", 3'(id), 32'h1000 + 32'(id), 32'h200 + 32'(4 * id), 5'(id), 2'(id));
      if (k == 0) begin
        check("retire_blocks_alloc_id", alloc_rob_id, 1);
        check("retire_blocks_alloc_rdy", alloc_ready, 1);
      end
    end
    tick();
    check("drain_empty", empty, 1);
    check("drain_idle", commit_valid, 0);

    // Stale completion to a non-busy id leaves no trace.
    reset_dut();
    do_wb(3'd5, 32'h77);
    check("stale_empty", empty, 1);
    check("stale_commit", commit_valid, 0);
    check("stale_tail", alloc_rob_id, 0);
    tick();
    check("stale_commit2", commit_valid, 0);
    for (int i = 0; i < 6; i++)
      do_alloc(32'h600 + 32'(i), 5'(i), 2'd0, 3'(i));
    pulses  = 0;
    last_id = '0;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        wb_valid = 1'b1; wb_rob_id = 3'(c); wb_result = 32'(c);
      end
      tick();
      wb_valid = 1'b0;
      if (commit_valid) begin
        pulses++;
        last_id = commit_rob_id;
      end
    end
    check("stale_pulses", pulses, 5);
    check("stale_last_id", last_id, 4);

    // Alloc and completion to the same free id on one edge: completion is dropped.
    reset_dut();
    alloc_valid = 1'b1; alloc_pc = 32'h300; alloc_rd = 5'd3; alloc_instr_type = 2'd2;
    wb_valid = 1'b1; wb_rob_id = 3'd0; wb_result = 32'h99;
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b0;
    tick();
    check("coll_no_commit", commit_valid, 0);
    tick();
    check("coll_no_commit2", commit_valid, 0);
    do_wb(3'd0, 32'h42);
    tick();
    expect_commit("coll", 3'd0, 32'h42, 32'h300, 5'd3, 2'd2);

    // Reset mid-flight discards everything, including a same-cycle completion.
    reset_dut();
    for (int i = 0; i < 4; i++)
      do_alloc(32'h700 + 32'(4 * i), 5'(i), 2'd1, 3'(i));
    wb_valid = 1'b1; wb_rob_id = 3'd0; wb_result = 32'hEE;
    reset = 1'b1;
    tick();
    reset = 1'b0; wb_valid = 1'b0;
    check("mid_commit", commit_valid, 0);
    check("mid_empty", empty, 1);
    check("mid_tail", alloc_rob_id, 0);
    tick();
    check("mid_commit2", commit_valid, 0);
    do_alloc(32'h800, 5'd8, 2'd3, 3'd0);
    do_wb(3'd0, 32'h5);
    tick();
    expect_commit("mid_head", 3'd0, 32'h5, 32'h800, 5'd8, 2'd3);
    tick();
    check("mid_final_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
